// File: rtl/native_mem_to_wishbone.sv
// native_mem_to_wishbone
// Bridges a native memory request interface onto a Wishbone classic bus as
// master. One request is captured, a single classic cycle is run until ack,
// and a one-cycle response pulse is returned to the native side.
// Optional feature macro: NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
//   When defined, an ack wait limit of timeout_cycles clocks aborts the cycle,
//   sets the sticky bus_err_o flag and returns 32'hFFFF_FFFF for reads.
module native_mem_to_wishbone #(
    parameter int address_width  = 16,
    parameter int timeout_cycles = 255
) (
    input  logic                     i_wb_clk,
    input  logic                     i_wb_rst,
    input  logic [address_width-1:0] address_i,
    input  logic [31:0]              data_i,
    input  logic [3:0]               write_strb_i,
    input  logic                     data_valid_i,
    output logic [31:0]              data_o,
    output logic                     data_valid_o,
    output logic                     busy_o,
    output logic                     bus_err_o,
    output logic [address_width-3:0] o_wb_adr,
    output logic [31:0]              o_wb_dat,
    output logic [3:0]               o_wb_sel,
    output logic                     o_wb_we,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    input  logic [31:0]              i_wb_rdt,
    input  logic                     i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Elaboration-time guard on the ack wait limit.
    if ((timeout_cycles < 1) || (timeout_cycles > 65535)) begin : g_bad_timeout
        $error("timeout_cycles must lie in 1..65535");
    end

    state_t                   state_q;
    logic [31:0]              data_q;
    logic                     data_valid_q;
    logic                     busy_q;
    logic                     bus_err_q;
    logic [address_width-3:0] adr_q;
    logic [31:0]              dat_q;
    logic [3:0]               sel_q;
    logic                     we_q;
    logic                     cyc_q;

    // Byte-lane bits of the native address play no part in a word access.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^address_i[1:0];

`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    // Counter value seen in the last CYCLE clock before the limit is reached.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    // Bridge FSM: capture request, run one classic cycle, pulse the response.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q      <= IDLE;
            data_q       <= 32'h0000_0000;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            bus_err_q    <= 1'b0;
            adr_q        <= '0;
            dat_q        <= 32'h0000_0000;
            sel_q        <= 4'h0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_valid_i) begin
                        adr_q   <= address_i[address_width-1:2];
                        dat_q   <= data_i;
                        we_q    <= |write_strb_i;
                        sel_q   <= (|write_strb_i) ? write_strb_i : 4'hF;
                        cyc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= CYCLE;
`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CYCLE: begin
                    if (i_wb_ack) begin
                        // Ack wins even when it coincides with the wait limit.
                        cyc_q        <= 1'b0;
                        we_q         <= 1'b0;
                        data_valid_q <= 1'b1;
                        state_q      <= RESP;
                        if (!we_q) begin
                            data_q <= i_wb_rdt;
                        end else begin
                            data_q <= data_q;
                        end
`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        cyc_q        <= 1'b0;
                        we_q         <= 1'b0;
                        data_valid_q <= 1'b1;
                        bus_err_q    <= 1'b1;
                        state_q      <= RESP;
                        if (!we_q) begin
                            data_q <= 32'hFFFF_FFFF;
                        end else begin
                            data_q <= data_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`else
                    end else begin
                        state_q <= CYCLE;
                    end
`endif
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign busy_o       = busy_q;
`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
    assign bus_err_o    = bus_err_q;
`else
    assign bus_err_o    = 1'b0;
    logic unused_bus_err_s;
    assign unused_bus_err_s = bus_err_q;
`endif
    assign o_wb_adr     = adr_q;
    assign o_wb_dat     = dat_q;
    assign o_wb_sel     = sel_q;
    assign o_wb_we      = we_q;
    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = cyc_q;

endmodule

// File: tb/tb_native_mem_to_wishbone.sv
// Self-checking bench for native_mem_to_wishbone: directed cases followed by
// randomized transactions against a behavioural model of the bridge.
module tb_native_mem_to_wishbone;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address_i;
    logic [31:0]   data_i;
    logic [3:0]    write_strb_i;
    logic          data_valid_i;
    logic [31:0]   data_o;
    logic          data_valid_o;
    logic          busy_o;
    logic          bus_err_o;
    logic [AW-3:0] wb_adr;
    logic [31:0]   wb_dat;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;
    logic [31:0]   wb_rdt;
    logic          wb_ack;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] exp_data;

    native_mem_to_wishbone #(.address_width(AW), .timeout_cycles(8)) dut (
        .i_wb_clk    (clk),
        .i_wb_rst    (rst),
        .address_i   (address_i),
        .data_i      (data_i),
        .write_strb_i(write_strb_i),
        .data_valid_i(data_valid_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .busy_o      (busy_o),
        .bus_err_o   (bus_err_o),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: present request, slave acks after 'waits' clocks.
    task automatic run_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int waits, input logic [31:0] rdt, input bit b2b,
                           input logic [AW-1:0] na, input logic [31:0] nd, input logic [3:0] ns);
        logic [AW-3:0] e_adr;
        logic          e_we;
        logic [3:0]    e_sel;
        e_adr = AW'(a) >> 2;
        e_we  = (s != 4'h0);
        e_sel = e_we ? s : 4'hF;
        address_i    = a;
        data_i       = d;
        write_strb_i = s;
        data_valid_i = 1'b1;
        @(negedge clk);
        for (int w = 0; w <= waits; w++) begin
            check_eq("cyc_hold", 32'(wb_cyc), 32'd1);
            check_eq("stb_hold", 32'(wb_stb), 32'd1);
            check_eq("adr", 32'(wb_adr), 32'(e_adr));
            check_eq("dat", wb_dat, d);
            check_eq("sel", 32'(wb_sel), 32'(e_sel));
            check_eq("we", 32'(wb_we), 32'(e_we));
            check_eq("dv_wait", 32'(data_valid_o), 32'd0);
            check_eq("busy_wait", 32'(busy_o), 32'd1);
            wb_ack       = (w == waits);
            wb_rdt       = (w == waits) ? rdt : $urandom;
            address_i    = AW'($urandom);
            data_i       = $urandom;
            write_strb_i = 4'($urandom);
            @(negedge clk);
        end
        wb_ack = 1'b0;
        wb_rdt = $urandom;
        if (!e_we) exp_data = rdt;
        check_eq("cyc_done", 32'(wb_cyc), 32'd0);
        check_eq("stb_done", 32'(wb_stb), 32'd0);
        check_eq("we_done", 32'(wb_we), 32'd0);
        check_eq("dv_resp", 32'(data_valid_o), 32'd1);
        check_eq("data_o", data_o, exp_data);
        check_eq("busy_resp", 32'(busy_o), 32'd1);
        check_eq("bus_err", 32'(bus_err_o), 32'd0);
        if (b2b) begin
            address_i    = na;
            data_i       = nd;
            write_strb_i = ns;
            data_valid_i = 1'b1;
        end else begin
            data_valid_i = 1'b0;
        end
        @(negedge clk);
        check_eq("dv_pulse", 32'(data_valid_o), 32'd0);
        check_eq("cyc_idle", 32'(wb_cyc), 32'd0);
        check_eq("busy_idle", 32'(busy_o), 32'd0);
    endtask

    // Idle clocks with stray acks that must be ignored.
    task automatic idle_gap(input int n);
        data_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            wb_ack = 1'($urandom);
            @(negedge clk);
            check_eq("gap_cyc", 32'(wb_cyc), 32'd0);
            check_eq("gap_dv", 32'(data_valid_o), 32'd0);
        end
        wb_ack = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ca, na;
        logic [31:0]   cd, nd;
        logic [3:0]    cs, ns;
        bit            b2b;
        rst = 1'b1;
        address_i = '0; data_i = 32'h0; write_strb_i = 4'h0; data_valid_i = 1'b0;
        wb_rdt = 32'h0; wb_ack = 1'b0;
        exp_data = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_data_o", data_o, 32'h0);
        check_eq("rst_dv", 32'(data_valid_o), 32'd0);
        check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
        check_eq("rst_stb", 32'(wb_stb), 32'd0);
        check_eq("rst_we", 32'(wb_we), 32'd0);
        check_eq("rst_adr", 32'(wb_adr), 32'd0);
        check_eq("rst_dat", wb_dat, 32'h0);
        check_eq("rst_sel", 32'(wb_sel), 32'd0);
        check_eq("rst_err", 32'(bus_err_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read, then a byte write with five wait states.
        run_txn(16'h1234, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, '0, 32'h0, 4'h0);
        check_eq("rd_adr_const", 32'(wb_adr), 32'h048D);
        run_txn(16'h0010, 32'hA5A5_A5A5, 4'b0100, 5, 32'h1111_2222, 1'b0, '0, 32'h0, 4'h0);
        check_eq("wr_keeps_data", data_o, 32'hCAFE_F00D);

        // Back-to-back: next request presented during the response cycle.
        run_txn(16'h0100, 32'h0, 4'h0, 1, 32'h0BAD_BEEF, 1'b1, 16'h0204, 32'h5555_AAAA, 4'hF);
        run_txn(16'h0204, 32'h5555_AAAA, 4'hF, 2, 32'h0, 1'b0, '0, 32'h0, 4'h0);

        // Reset in the middle of a cycle.
        address_i = 16'h2000; data_i = 32'h0; write_strb_i = 4'h0; data_valid_i = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_cyc", 32'(wb_cyc), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_cyc", 32'(wb_cyc), 32'd0);
        check_eq("async_stb", 32'(wb_stb), 32'd0);
        check_eq("async_busy", 32'(busy_o), 32'd0);
        data_valid_i = 1'b0;
        wb_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_dv", 32'(data_valid_o), 32'd0);
            check_eq("post_rst_cyc", 32'(wb_cyc), 32'd0);
        end
        wb_ack = 1'b0;
        check_eq("post_rst_data", data_o, 32'h0);
        run_txn(16'h3008, 32'h0, 4'h0, 0, 32'h7654_3210, 1'b0, '0, 32'h0, 4'h0);

        // Randomized transactions.
        ca = AW'($urandom); cd = $urandom; cs = 1'($urandom) ? 4'($urandom) : 4'h0;
        for (int i = 0; i < 40; i++) begin
            na = AW'($urandom); nd = $urandom; ns = 1'($urandom) ? 4'($urandom) : 4'h0;
            b2b = 1'($urandom);
            run_txn(ca, cd, cs, int'($urandom_range(0, 6)), $urandom, b2b, na, nd, ns);
            if (!b2b) idle_gap(int'($urandom_range(0, 2)));
            ca = na; cd = nd; cs = ns;
        end

`ifdef NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN
        // Read that never gets an ack times out after 8 CYCLE clocks.
        address_i = 16'h0040; data_i = 32'h0; write_strb_i = 4'h0; data_valid_i = 1'b1;
        wb_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq("to_cyc", 32'(wb_cyc), 32'd1);
            check_eq("to_dv", 32'(data_valid_o), 32'd0);
            check_eq("to_err_pre", 32'(bus_err_o), 32'd0);
            @(negedge clk);
        end
        check_eq("to_cyc_drop", 32'(wb_cyc), 32'd0);
        check_eq("to_dv_resp", 32'(data_valid_o), 32'd1);
        check_eq("to_data", data_o, 32'hFFFF_FFFF);
        check_eq("to_err", 32'(bus_err_o), 32'd1);
        data_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("to_err_sticky", 32'(bus_err_o), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("to_err_clr", 32'(bus_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        check_eq("err_tied", 32'(bus_err_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/native_mem_to_wishbone.md
Name: native_mem_to_wishbone

Overview:
- Bridges a native memory initiator onto a Wishbone classic bus as bus master.
- Captures one native request at a time, runs a single Wishbone cycle, waits for ack, then returns a one-cycle response to the native side.
- Used where a native-interface core (CPU/DMA) must reach Wishbone-attached peripherals or memory.

Parameters:
- address_width, 16, byte-address width of the native side; Wishbone word address is address_width-1:2.
- timeout_cycles, 255, ack wait limit in clocks; used only with the optional feature; legal range 1..65535.

Ports:
- i_wb_clk  in  1  clock; all logic on rising edge.
- i_wb_rst  in  1  reset; asynchronous, active-high.
- address_i  in  address_width  native byte address; bits 1:0 ignored.
- data_i  in  32  native write data.
- write_strb_i  in  4  byte write strobes; 4'b0000 means read.
- data_valid_i  in  1  native request valid; level, held until response.
- data_o  out  32  read data returned to the native side.
- data_valid_o  out  1  one-cycle response pulse (read data valid / write done).
- busy_o  out  1  high whenever state is not IDLE.
- bus_err_o  out  1  sticky timeout flag; constant 0 without the optional feature.
- o_wb_adr  out  address_width-2  Wishbone word address.
- o_wb_dat  out  32  Wishbone write data.
- o_wb_sel  out  4  Wishbone byte select.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe; identical to o_wb_cyc.
- i_wb_rdt  in  32  Wishbone read data.
- i_wb_ack  in  1  Wishbone acknowledge.

Behaviour:
- Reset values (asynchronous): state IDLE; data_o 0; data_valid_o 0; o_wb_cyc/o_wb_stb/o_wb_we 0; o_wb_adr/o_wb_dat 0; o_wb_sel 0; bus_err_o 0.
- Reset mid-cycle:
  - cyc/stb drop asynchronously.
  - No response is delivered.
  - Any captured request is discarded.
- All outputs are registered. Wishbone outputs come from holding registers only, never combinationally from native inputs.
- States:
  - IDLE: busy_o=0. If data_valid_i=1, capture address_i[aw-1:2] into o_wb_adr and data_i into o_wb_dat. we = |write_strb_i. sel = write_strb_i if write, else 4'hF. Set cyc=stb=1 and go to CYCLE.
  - CYCLE: cyc=stb=1. Address, data, sel and we are held stable regardless of native inputs. On i_wb_ack=1: clear cyc/stb/we. If read, register i_wb_rdt into data_o. Set data_valid_o=1 and go to RESP.
  - RESP: data_valid_o=1 for exactly this cycle; next state is IDLE.
- Latency: request seen at edge N; cyc high from cycle N+1. Ack sampled at edge K gives data_valid_o high in cycle K+1 and IDLE in K+2.
- Zero-wait slave (ack in the first CYCLE clock): request to response is 3 clocks.
- Native handshake rules:
  - The initiator holds address/data/strobes/data_valid_i until it sees data_valid_o.
  - It drops data_valid_i in the cycle after data_valid_o, or presents the next request.
  - data_valid_i high in IDLE always starts a new cycle. data_valid_i in CYCLE/RESP is ignored.
- Writes leave data_o unchanged.
- i_wb_ack outside CYCLE is ignored. i_wb_rdt is sampled only on ack.
- cyc never stays asserted for more than one ack. Only single classic cycles are issued; no bursts, no pipelining.

Optional Feature:
- Macro NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(timeout_cycles+1) clears on entry to CYCLE and increments each CYCLE clock without ack.
  - When it reaches timeout_cycles with no ack, drop cyc/stb, set bus_err_o=1 (sticky until reset), and go to RESP with data_valid_o=1.
  - A timed-out read returns data_o=32'hFFFF_FFFF.
  - Ack in the same cycle as expiry counts as a normal completion.
- Not defined: no counter; CYCLE waits indefinitely for ack; bus_err_o tied 0.

Test Plan:
- Read, zero-wait slave: address_i=16'h1234, strb 0, valid; slave acks first cycle with rdt=32'hCAFEF00D -> o_wb_adr=14'h048D, sel=4'hF, we=0; data_o=32'hCAFEF00D with data_valid_o pulse 3 clocks after request.
- Byte write with 5 wait states: address_i=16'h0010, data_i=32'hA5A5A5A5, strb=4'b0100 -> sel=4'b0100, we=1, cyc held 6 clocks; one data_valid_o pulse; data_o unchanged.
- Back-to-back: data_valid_i held high through response with new address -> second cycle starts the clock after RESP; no duplicate cycle for the first request.
- Native inputs change during CYCLE -> o_wb_adr/o_wb_dat/o_wb_sel stay at captured values.
- Assert i_wb_rst while cyc=1 -> cyc/stb 0 immediately; no data_valid_o; next request after reset completes normally.
- With NATIVE_MEM_TO_WISHBONE_TIMEOUT_EN and timeout_cycles=8, read with no ack -> cyc drops after 8 CYCLE clocks, data_o=32'hFFFF_FFFF, data_valid_o pulse, bus_err_o=1 until reset.
